// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the stall/flush sequencer and the pipeline it governs.
// The pipeline side uses the master modport; the sequencer uses the slave modport.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs_i;
   logic [4:0]       id_rt_i;
   logic             id_use_rs_i;
   logic             id_use_rt_i;
   logic             ex_rmem_i;
   logic [4:0]       ex_waddr_i;
   logic             div_start_i;
   logic             div_done_i;
   logic             ibus_busy_i;
   logic             dbus_busy_i;
   logic             except_i;
   logic [31:0]      except_pc_i;
   logic [4:0]       stall_o;
   logic [4:0]       flush_o;
   logic             redirect_o;
   logic [31:0]      redirect_pc_o;
   logic             div_cancel_o;
   logic             div_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;
   // Sequencer state: 0 RUN, 1 DIV_WAIT, 2 EXC_PEND
   logic [1:0]       dbg_state_o;

   modport master (
      output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_rmem_i, ex_waddr_i,
             div_start_i, div_done_i, ibus_busy_i, dbus_busy_i, except_i, except_pc_i,
      input  stall_o, flush_o, redirect_o, redirect_pc_o, div_cancel_o,
             div_timeout_o, stall_cnt_o, dbg_state_o
   );

   modport slave (
      input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i, ex_rmem_i, ex_waddr_i,
             div_start_i, div_done_i, ibus_busy_i, dbus_busy_i, except_i, except_pc_i,
      output stall_o, flush_o, redirect_o, redirect_pc_o, div_cancel_o,
             div_timeout_o, stall_cnt_o, dbg_state_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use, divide wait,
// bus wait and precise exception redirects deferred until both buses are idle.
module pipe_hazard_ctrl #(
   parameter int DIV_MAX = 40,
   parameter int CNT_W   = 32
) (
   input logic               clk_i,
   input logic               rst_i,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int DIV_W = $clog2(DIV_MAX + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_DIV_WAIT = 2'd1,
      ST_EXC_PEND = 2'd2
   } state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_div_cnt;
   logic [31:0]      r_exc_pc;
   logic             r_timeout;
   logic [CNT_W-1:0] r_stall_cnt;

   state_t      w_next;
   logic [4:0]  w_stall;
   logic [4:0]  w_flush;
   logic        w_redirect;
   logic [31:0] w_redirect_pc;
   logic        w_cancel;
   logic        w_latch_pc;
   logic        w_div_clr;
   logic        w_set_timeout;
   logic        w_busy;
   logic        w_load_use;
   logic        w_div_last;

   always_comb begin
      w_busy     = bus.ibus_busy_i | bus.dbus_busy_i;
      w_load_use = bus.ex_rmem_i && (bus.ex_waddr_i != 5'd0) &&
                   ((bus.id_use_rs_i && (bus.id_rs_i == bus.ex_waddr_i)) ||
                    (bus.id_use_rt_i && (bus.id_rt_i == bus.ex_waddr_i)));
      w_div_last = (r_div_cnt == DIV_W'(DIV_MAX - 1));

      w_next        = r_state;
      w_stall       = 5'b00000;
      w_flush       = 5'b00000;
      w_redirect    = 1'b0;
      w_redirect_pc = 32'd0;
      w_cancel      = 1'b0;
      w_latch_pc    = 1'b0;
      w_div_clr     = 1'b0;
      w_set_timeout = 1'b0;

      case (r_state)
         ST_EXC_PEND: begin
            if (w_busy) begin
               w_stall = 5'b11111;
            end else begin
               w_flush       = 5'b11111;
               w_redirect    = 1'b1;
               w_redirect_pc = r_exc_pc;
               w_next        = ST_RUN;
            end
         end
         default: begin
            if (bus.except_i) begin
               // An exception during a divide also kills the divider.
               w_cancel = (r_state == ST_DIV_WAIT);
               if (!w_busy) begin
                  w_flush       = 5'b11111;
                  w_redirect    = 1'b1;
                  w_redirect_pc = bus.except_pc_i;
                  w_next        = ST_RUN;
               end else begin
                  w_stall    = 5'b11111;
                  w_latch_pc = 1'b1;
                  w_next     = ST_EXC_PEND;
               end
            end else if (r_state == ST_RUN) begin
               if (bus.dbus_busy_i) begin
                  w_stall = 5'b01111;
                  w_flush = 5'b10000;
               end else if (bus.div_start_i && !bus.div_done_i) begin
                  w_stall   = 5'b00111;
                  w_flush   = 5'b01000;
                  w_div_clr = 1'b1;
                  w_next    = ST_DIV_WAIT;
               end else if (w_load_use) begin
                  w_stall = 5'b00011;
                  w_flush = 5'b00100;
               end else if (bus.ibus_busy_i) begin
                  w_stall = 5'b00001;
                  w_flush = 5'b00010;
               end
            end else begin
               if (bus.dbus_busy_i) begin
                  w_stall = 5'b01111;
                  w_flush = 5'b10000;
               end else if (!bus.div_done_i && !w_div_last) begin
                  w_stall = 5'b00111;
                  w_flush = 5'b01000;
               end
               // A done seen under a data-bus wait is held off until the bus frees.
               if (bus.div_done_i && !bus.dbus_busy_i) begin
                  w_next = ST_RUN;
               end else if (w_div_last && !bus.div_done_i) begin
                  w_cancel      = 1'b1;
                  w_set_timeout = 1'b1;
                  w_next        = ST_RUN;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_RUN;
         r_div_cnt   <= '0;
         r_exc_pc    <= 32'd0;
         r_timeout   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_div_clr) begin
            r_div_cnt <= '0;
         end else if (r_state == ST_DIV_WAIT) begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end
         if (w_latch_pc) begin
            r_exc_pc <= bus.except_pc_i;
         end
         if (w_set_timeout) begin
            r_timeout <= 1'b1;
         end
         if ((w_stall != 5'b00000) && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.stall_o       = w_stall;
   assign bus.flush_o       = w_flush;
   assign bus.redirect_o    = w_redirect;
   assign bus.redirect_pc_o = w_redirect_pc;
   assign bus.div_cancel_o  = w_cancel;
   assign bus.div_timeout_o = r_timeout;
   assign bus.stall_cnt_o   = r_stall_cnt;
   assign bus.dbg_state_o   = r_state;
endmodule
